conv_frame_scheduler: RTL and testbench
=======================================

Name: conv_frame_scheduler

Overview:
Sequences one frame through the two-stage RGB 3x3 convolution pipeline. It pulses weight load, then streams IMAGE_SIZE x IMAGE_SIZE RGB pixels from an upstream valid/ready source into the pipeline's pixel inputs, with a configurable row gap. It counts second-stage output beats, reports frame completion, and raises an error if the pipeline stops producing. It sits between the frame source (camera/DMA) and the convolution datapath.

Parameters:
DATA_WIDTH, 8, bits per colour channel.
IMAGE_SIZE, 224, input frame side in pixels.
OUT_SIZE, 220, second-stage output side (IMAGE_SIZE-4).
WLOAD_CYCLES, 9, cycles load_weight is held high.
ROW_GAP, 2, idle cycles inserted after each input row.
TIMEOUT, 4096, max cycles in DRAIN without an output beat.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE
abort  in  1  synchronous abort to IDLE
src_r/src_g/src_b  in  DATA_WIDTH each  upstream pixel
src_valid  in  1  upstream pixel valid
src_ready  out  1  scheduler accepts pixel
load_weight  out  1  weight load strobe to the datapath
pix_r/pix_g/pix_b  out  DATA_WIDTH each  registered pixel to the datapath
pix_valid  out  1  drives pixel_valid_r/g/b together
conv_valid  in  1  second-stage output valid from the datapath
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse on completion
timeout_err  out  1  sticky until next start
out_count  out  16  second-stage beats counted this frame

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including src_ready, load_weight, pix_*, pix_valid, busy, frame_done, timeout_err and out_count. All counters 0.
- States and transitions:
  - IDLE: on start, go to LOAD_W; clear out_count and timeout_err.
  - LOAD_W: load_weight=1 for exactly WLOAD_CYCLES cycles, then go to STREAM.
  - STREAM: src_ready=1 except during gap cycles. Handshake is src_valid & src_ready. Each handshake registers src_* to pix_* with pix_valid=1 the next cycle (latency 1). A cycle with no handshake gives pix_valid=0 and pix_* held. Column counter 0..IMAGE_SIZE-1. On the last column, src_ready=0 for ROW_GAP cycles. After pixel IMAGE_SIZE^2 is accepted, go to DRAIN; src_ready stays 0.
  - DRAIN: each conv_valid increments out_count (also counted in STREAM). When out_count reaches OUT_SIZE^2, pulse frame_done and go to IDLE. The idle counter resets on each conv_valid; reaching TIMEOUT sets timeout_err and goes to IDLE without frame_done.
- conv_valid in IDLE or LOAD_W is ignored; it is not counted.
- start while busy is ignored.
- abort in any state goes to IDLE next cycle: pix_valid=0, load_weight=0, src_ready=0. out_count is held for debug. abort has priority over every other event in the same cycle.
- Completion and abort in the same cycle: abort wins and frame_done is not pulsed.
- out_count saturates at 16'hFFFF.
- Reset mid-frame returns to IDLE immediately. No partial state survives.

Optional Feature:
CONV_SCHED_PERF_EN:
- Defined: adds output cycle_count [31:0], which counts clocks from leaving IDLE to frame_done or timeout. It is held after the frame and cleared on start. Also adds output stall_count [31:0], which counts STREAM cycles with src_ready=1 and src_valid=0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package conv_sched_pkg: state enum (IDLE, LOAD_W, STREAM, DRAIN); localparams PIXELS = IMAGE_SIZE*IMAGE_SIZE and OUTPUTS = OUT_SIZE*OUT_SIZE; counter width function clog2-based.
- Sub-module conv_raster_counter: row/column counter with row-gap insertion. It outputs last_col, last_pix and in_gap. It is instantiated once in STREAM.

Test Plan:
- Reset, then start with IMAGE_SIZE=5, OUT_SIZE=1, src_valid always 1 -> load_weight high 9 cycles; 25 pix_valid beats in raster order; src_ready low 2 cycles after every 5th beat.
- Data check: src_r=col, src_g=row, src_b=0xAA -> pix_* equal the inputs exactly one cycle after each handshake.
- Random src_valid gaps (50%) -> no pixel dropped or duplicated; pix_valid count = 25.
- Drive 1 conv_valid after streaming -> frame_done pulses once; out_count=1; busy falls the same cycle frame_done is seen.
- No conv_valid with TIMEOUT=16 -> timeout_err=1 after 16 DRAIN cycles; no frame_done; next start clears timeout_err.
- abort asserted mid-STREAM at pixel 12 -> next cycle IDLE, src_ready=0, pix_valid=0; rst pulled low mid-LOAD_W -> load_weight=0 immediately.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_sched_pkg
// Shared types and helpers for the convolution frame scheduler.
//   sched_state_t : scheduler FSM states (IDLE, LOAD_W, STREAM, DRAIN)
//   PIXELS        : input pixels per frame at the default geometry
//   OUTPUTS       : second-stage output beats per frame at the default geometry
//   cnt_width()   : bits needed for a counter running 0..n-1 (minimum 1)
// ---------------------------------------------------------------------------
package conv_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } sched_state_t;

   localparam int unsigned DEF_IMAGE_SIZE = 224;
   localparam int unsigned DEF_OUT_SIZE   = 220;
   localparam int unsigned PIXELS         = DEF_IMAGE_SIZE * DEF_IMAGE_SIZE;
   localparam int unsigned OUTPUTS        = DEF_OUT_SIZE * DEF_OUT_SIZE;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_raster_counter.sv
// ---------------------------------------------------------------------------
// conv_raster_counter
// Column/row position of the input raster with row-gap insertion.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   i_clear       : synchronous return to pixel (0,0), gap cleared
//   i_advance     : a pixel was accepted this cycle
//   o_last_col    : current position is the last column of a row
//   o_last_pix    : current position is the last pixel of the frame
//   o_in_gap      : inside the idle gap that follows each completed row
// ---------------------------------------------------------------------------
module conv_raster_counter
   import conv_sched_pkg::*;
#(
   parameter int unsigned IMAGE_SIZE = 224,
   parameter int unsigned ROW_GAP    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_advance,
   output logic o_last_col,
   output logic o_last_pix,
   output logic o_in_gap
);

   localparam int unsigned CW = cnt_width(IMAGE_SIZE);
   localparam int unsigned GW = cnt_width(ROW_GAP + 1);
   localparam logic [CW-1:0] POS_LAST = CW'(IMAGE_SIZE - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(ROW_GAP);

   logic [CW-1:0] r_col;
   logic [CW-1:0] r_row;
   logic [GW-1:0] r_gap;

   assign o_last_col = (r_col == POS_LAST);
   assign o_last_pix = (r_col == POS_LAST) && (r_row == POS_LAST);
   assign o_in_gap   = (r_gap != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
         r_gap <= '0;
      end else if (i_clear) begin
         r_col <= '0;
         r_row <= '0;
         r_gap <= '0;
      end else begin
         if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
         end
         if (i_advance) begin
            if (o_last_col) begin
               r_col <= '0;
               r_row <= o_last_pix ? '0 : r_row + 1'b1;
               r_gap <= GAP_LOAD;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/conv_frame_scheduler.sv
// ---------------------------------------------------------------------------
// conv_frame_scheduler
// Sequences one frame through the two-stage RGB 3x3 convolution pipeline:
// weight-load strobe, raster pixel streaming with row gaps, then draining and
// counting second-stage output beats with a no-progress timeout.
// Optional feature macro: CONV_SCHED_PERF_EN (adds cycle_count, stall_count).
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   start                     : one-cycle frame start (honoured in IDLE only)
//   abort                     : synchronous return to IDLE, highest priority
//   src_r/g/b, src_valid      : upstream pixel and valid
//   src_ready                 : upstream pixel accepted when src_valid is high
//   load_weight               : weight load strobe to the datapath
//   pix_r/g/b, pix_valid      : registered pixel to the datapath
//   conv_valid                : second-stage output beat from the datapath
//   busy                      : scheduler not in IDLE
//   frame_done                : one-cycle completion pulse
//   timeout_err               : sticky until the next accepted start
//   out_count                 : saturating count of output beats this frame
//   cycle_count, stall_count  : (CONV_SCHED_PERF_EN) frame cycles and
//                               STREAM cycles ready but starved
// ---------------------------------------------------------------------------
module conv_frame_scheduler
   import conv_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned IMAGE_SIZE   = 224,
   parameter int unsigned OUT_SIZE     = 220,
   parameter int unsigned WLOAD_CYCLES = 9,
   parameter int unsigned ROW_GAP      = 2,
   parameter int unsigned TIMEOUT      = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] src_r,
   input  logic [DATA_WIDTH-1:0] src_g,
   input  logic [DATA_WIDTH-1:0] src_b,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic                  load_weight,
   output logic [DATA_WIDTH-1:0] pix_r,
   output logic [DATA_WIDTH-1:0] pix_g,
   output logic [DATA_WIDTH-1:0] pix_b,
   output logic                  pix_valid,
   input  logic                  conv_valid,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  timeout_err,
`ifdef CONV_SCHED_PERF_EN
   output logic [31:0]           cycle_count,
   output logic [31:0]           stall_count,
`endif
   output logic [15:0]           out_count
);

   localparam int unsigned WW = cnt_width(WLOAD_CYCLES);
   localparam int unsigned TW = cnt_width(TIMEOUT);
   localparam int unsigned FRAME_OUTPUTS = OUT_SIZE * OUT_SIZE;
   localparam logic [WW-1:0] WLOAD_LAST = WW'(WLOAD_CYCLES - 1);
   localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

   sched_state_t          r_state;
   logic [WW-1:0]         r_wcnt;
   logic [TW-1:0]         r_idle;
   logic                  r_load_weight;
   logic [DATA_WIDTH-1:0] r_pix_r;
   logic [DATA_WIDTH-1:0] r_pix_g;
   logic [DATA_WIDTH-1:0] r_pix_b;
   logic                  r_pix_valid;
   logic                  r_frame_done;
   logic                  r_timeout_err;
   logic [15:0]           r_out_count;

   logic                  w_ready;
   logic                  w_hs;
   logic                  w_last_col;
   logic                  w_last_pix;
   logic                  w_in_gap;
   logic                  w_raster_clear;
   logic [15:0]           w_cnt_next;

   // Abort gates ready so the source never sees a handshake that the
   // scheduler then discards.
   assign w_ready        = (r_state == STREAM) && !w_in_gap && !abort;
   assign w_hs           = src_valid && w_ready;
   assign w_raster_clear = (r_state != STREAM) || abort;
   assign w_cnt_next     = (conv_valid && (r_out_count != 16'hFFFF)) ?
                           r_out_count + 16'd1 : r_out_count;

   conv_raster_counter #(
      .IMAGE_SIZE (IMAGE_SIZE),
      .ROW_GAP    (ROW_GAP)
   ) u_raster (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_raster_clear),
      .i_advance  (w_hs),
      .o_last_col (w_last_col),
      .o_last_pix (w_last_pix),
      .o_in_gap   (w_in_gap)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_wcnt        <= '0;
         r_idle        <= '0;
         r_load_weight <= 1'b0;
         r_pix_r       <= '0;
         r_pix_g       <= '0;
         r_pix_b       <= '0;
         r_pix_valid   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_timeout_err <= 1'b0;
         r_out_count   <= '0;
      end else begin
         r_frame_done <= 1'b0;
         r_pix_valid  <= 1'b0;
         if (abort) begin
            r_state       <= IDLE;
            r_load_weight <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state       <= LOAD_W;
                     r_load_weight <= 1'b1;
                     r_wcnt        <= '0;
                     r_out_count   <= '0;
                     r_timeout_err <= 1'b0;
                  end
               end
               LOAD_W: begin
                  if (r_wcnt == WLOAD_LAST) begin
                     r_load_weight <= 1'b0;
                     r_state       <= STREAM;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
               STREAM: begin
                  r_out_count <= w_cnt_next;
                  if (w_hs) begin
                     r_pix_r     <= src_r;
                     r_pix_g     <= src_g;
                     r_pix_b     <= src_b;
                     r_pix_valid <= 1'b1;
                     if (w_last_col && w_last_pix) begin
                        r_state <= DRAIN;
                        r_idle  <= '0;
                     end
                  end
               end
               DRAIN: begin
                  r_out_count <= w_cnt_next;
                  // Completion is judged on the post-increment count so the
                  // final beat ends the frame in the cycle it arrives.
                  if (32'(w_cnt_next) >= FRAME_OUTPUTS) begin
                     r_frame_done <= 1'b1;
                     r_state      <= IDLE;
                  end else if (conv_valid) begin
                     r_idle <= '0;
                  end else if (r_idle == IDLE_LAST) begin
                     r_timeout_err <= 1'b1;
                     r_state       <= IDLE;
                  end else begin
                     r_idle <= r_idle + 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] r_cycle_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cycle_count <= '0;
         r_stall_count <= '0;
      end else if (r_state == IDLE) begin
         if (start && !abort) begin
            r_cycle_count <= '0;
            r_stall_count <= '0;
         end
      end else begin
         r_cycle_count <= r_cycle_count + 32'd1;
         if (w_ready && !src_valid) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign cycle_count = r_cycle_count;
   assign stall_count = r_stall_count;
`endif

   assign src_ready   = w_ready;
   assign load_weight = r_load_weight;
   assign pix_r       = r_pix_r;
   assign pix_g       = r_pix_g;
   assign pix_b       = r_pix_b;
   assign pix_valid   = r_pix_valid;
   assign busy        = (r_state != IDLE);
   assign frame_done  = r_frame_done;
   assign timeout_err = r_timeout_err;
   assign out_count   = r_out_count;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_frame_scheduler
// Directed bench for conv_frame_scheduler at a 5x5 frame, one output beat,
// 9-cycle weight load, 2-cycle row gap and 16-cycle drain timeout.
// ---------------------------------------------------------------------------
module tb_conv_frame_scheduler;

   localparam int NV = 47;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  src_r = '0;
   logic [7:0]  src_g = '0;
   logic [7:0]  src_b = '0;
   logic        src_valid = 1'b0;
   logic        conv_valid = 1'b0;
   logic        src_ready;
   logic        load_weight;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic        pix_valid;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;
   logic [15:0] out_count;

   int n_pass  = 0;
   int n_total = 0;

   conv_frame_scheduler #(
      .DATA_WIDTH   (8),
      .IMAGE_SIZE   (5),
      .OUT_SIZE     (1),
      .WLOAD_CYCLES (9),
      .ROW_GAP      (2),
      .TIMEOUT      (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .src_r       (src_r),
      .src_g       (src_g),
      .src_b       (src_b),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .load_weight (load_weight),
      .pix_r       (pix_r),
      .pix_g       (pix_g),
      .pix_b       (pix_b),
      .pix_valid   (pix_valid),
      .conv_valid  (conv_valid),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        valid;
      logic        conv;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [45:0] exp;
   } vec_t;

   vec_t tbl [NV];

   // {src_ready, load_weight, pix_valid, busy, frame_done, timeout_err,
   //  out_count, pix_r, pix_g, pix_b}
   function automatic logic [45:0] obs();
      return {src_ready, load_weight, pix_valid, busy, frame_done, timeout_err,
              out_count, pix_r, pix_g, pix_b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_pixel(input int idx);
      src_r = 8'(idx % 5);
      src_g = 8'(idx / 5);
      src_b = 8'hAA;
   endtask

   initial begin
      int         acc;
      logic       rdy;
      logic       prev_rdy;
      logic [7:0] hr, hg, hb;
      int         idx, pv_idx, pv_cnt, ord_err, last_hs, tcyc, lw;
      logic       seen_fd, tbusy, ab_done;

      // Expected timeline of a frame with src_valid held high: start in
      // cycle 0, weight load in 1..9, rows accepted in 5-cycle bursts every
      // 7 cycles from cycle 10, one output beat in cycle 44, done in 45.
      acc = 0; prev_rdy = 1'b0; hr = '0; hg = '0; hb = '0;
      for (int c = 0; c < NV; c++) begin
         tbl[c].start = (c == 0);
         tbl[c].valid = 1'b1;
         tbl[c].conv  = (c == 44);
         tbl[c].r     = 8'(acc % 5);
         tbl[c].g     = 8'(acc / 5);
         tbl[c].b     = 8'hAA;
         rdy = (c >= 10) && (c <= 42) && (((c - 10) % 7) < 5);
         tbl[c].exp = {rdy, (c >= 1 && c <= 9), prev_rdy, (c >= 1 && c <= 44),
                       (c == 45), 1'b0, ((c >= 45) ? 16'd1 : 16'd0), hr, hg, hb};
         if (rdy) begin
            hr = tbl[c].r; hg = tbl[c].g; hb = tbl[c].b;
            acc++;
         end
         prev_rdy = rdy;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'(obs()), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Frame 1: table-driven stream, data and completion
      for (int c = 0; c < NV; c++) begin
         start      = tbl[c].start;
         src_valid  = tbl[c].valid;
         conv_valid = tbl[c].conv;
         src_r      = tbl[c].r;
         src_g      = tbl[c].g;
         src_b      = tbl[c].b;
         @(negedge clk);
         check($sformatf("vec%0d", c), 64'(obs()), 64'(tbl[c].exp));
         @(posedge clk); #1;
      end
      start = 1'b0; src_valid = 1'b0; conv_valid = 1'b0;

      // Frame 2: random source gaps, no output beats -> timeout
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idx = 0; pv_idx = 0; pv_cnt = 0; ord_err = 0; last_hs = -1; tcyc = -1;
      seen_fd = 1'b0; tbusy = 1'b1;
      for (int c = 0; c < 600 && tcyc < 0; c++) begin
         src_valid = (idx < 25) ? 1'($urandom_range(0, 1)) : 1'b0;
         drive_pixel(idx);
         @(negedge clk);
         if (pix_valid) begin
            if (pix_r != 8'(pv_idx % 5) || pix_g != 8'(pv_idx / 5) || pix_b != 8'hAA)
               ord_err++;
            pv_idx++;
            pv_cnt++;
         end
         if (frame_done) seen_fd = 1'b1;
         if (timeout_err) begin
            tcyc  = c;
            tbusy = busy;
         end
         if (src_valid && src_ready) begin
            if (idx == 24) last_hs = c;
            idx++;
         end
         @(posedge clk); #1;
      end
      src_valid = 1'b0;
      check("rand_pix_count", 64'(pv_cnt), 64'd25);
      check("rand_pix_order", 64'(ord_err), 64'd0);
      check("timeout_latency", 64'(tcyc - last_hs), 64'd17);
      check("timeout_no_done", 64'(seen_fd), 64'd0);
      check("timeout_idle", 64'(tbusy), 64'd0);

      // Frame 3: start clears timeout, conv_valid ignored in LOAD_W,
      // start while busy ignored, counted in STREAM, abort at pixel 12
      start = 1'b1;
      @(negedge clk);
      check("timeout_sticky", 64'(timeout_err), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      lw = 0;
      for (int c = 1; c <= 9; c++) begin
         conv_valid = 1'b1;
         start      = (c == 4);
         @(negedge clk);
         if (load_weight) lw++;
         if (c == 1) check("start_clears_timeout", 64'({timeout_err, busy}), 64'b01);
         @(posedge clk); #1;
      end
      start = 1'b0;
      idx = 0; ab_done = 1'b0;
      for (int c = 10; c < 90 && !ab_done; c++) begin
         conv_valid = (c < 13);
         src_valid  = 1'b1;
         drive_pixel(idx);
         abort      = (idx == 12);
         @(negedge clk);
         if (load_weight) lw++;
         if (c == 10) check("loadw_conv_ignored", 64'(out_count), 64'd0);
         if (abort) begin
            check("abort_ready_gated", 64'(src_ready), 64'd0);
            ab_done = 1'b1;
         end else if (src_ready) begin
            idx++;
         end
         @(posedge clk); #1;
      end
      abort = 1'b0; src_valid = 1'b0; conv_valid = 1'b0;
      check("loadw_length", 64'(lw), 64'd9);
      @(negedge clk);
      check("abort_to_idle", 64'({busy, src_ready, pix_valid, load_weight}), 64'd0);
      check("abort_holds_count", 64'(out_count), 64'd3);
      @(posedge clk); #1;
      conv_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      conv_valid = 1'b0;
      @(negedge clk);
      check("idle_conv_ignored", 64'(out_count), 64'd3);
      @(posedge clk); #1;

      // Frame 4: completion beat and abort in the same DRAIN cycle
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_valid = 1'b1;
      idx = 0;
      for (int c = 0; c < 120 && idx < 25; c++) begin
         drive_pixel(idx);
         @(negedge clk);
         if (src_ready) idx++;
         @(posedge clk); #1;
      end
      src_valid = 1'b0;
      check("frame4_streamed", 64'(idx), 64'd25);
      conv_valid = 1'b1;
      abort      = 1'b1;
      @(negedge clk);
      check("drain_state", 64'({busy, src_ready}), 64'b10);
      @(posedge clk); #1;
      conv_valid = 1'b0;
      abort      = 1'b0;
      @(negedge clk);
      check("abort_beats_done", 64'({frame_done, busy, out_count}), 64'd0);
      @(posedge clk); #1;

      // Reset asserted in LOAD_W clears outputs immediately
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("loadw_before_reset", 64'(load_weight), 64'd1);
      rst = 1'b0;
      #1;
      check("reset_async", 64'({load_weight, busy}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_reset_idle", 64'(obs()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
